// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: requested access / permission encoding and entry address-matching mode.
package rv_iopmp_pkg;

    typedef logic [2:0] access_t;

    localparam access_t ACCESS_R = 3'b001;
    localparam access_t ACCESS_W = 3'b010;
    localparam access_t ACCESS_X = 3'b100;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_TOR   = 2'd1,
        MODE_NA4   = 2'd2,
        MODE_NAPOT = 2'd3
    } mode_t;

endpackage

// File: rtl/rv_iopmp_walk_matcher.sv
// Sequential IOPMP matcher: walks the entry table ENTRIES_PER_CYCLE lanes per cycle and issues one verdict.
// Define IOPMP_EARLY_EXIT_EN to stop on the first priority decision; otherwise latency is constant.
module rv_iopmp_walk_matcher
    import rv_iopmp_pkg::*;
#(
    parameter int NUM_ENTRIES       = 16,
    parameter int ENTRIES_PER_CYCLE = 4,
    parameter int PRIO_ENTRIES      = 8,
    parameter int ADDR_WIDTH        = 64,
    parameter int DATA_WIDTH        = 64,
    parameter int LEN               = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic [ADDR_WIDTH-1:0]               req_addr_i,
    input  logic [$clog2(DATA_WIDTH/8):0]       req_num_bytes_i,
    input  access_t                             req_access_i,
    input  logic [NUM_ENTRIES-1:0]              req_entry_mask_i,
    output logic                                entry_rd_en_o,
    output logic [$clog2(NUM_ENTRIES)-1:0]      entry_rd_idx_o,
    input  logic [ENTRIES_PER_CYCLE*LEN-1:0]    entry_addr_i,
    input  logic [ENTRIES_PER_CYCLE*LEN-1:0]    entry_addrh_i,
    input  logic [ENTRIES_PER_CYCLE*2-1:0]      entry_mode_i,
    input  logic [ENTRIES_PER_CYCLE*3-1:0]      entry_perm_i,
    output logic                                rsp_valid_o,
    input  logic                                rsp_ready_i,
    output logic                                rsp_allow_o,
    output logic                                rsp_match_o,
    output logic                                rsp_partial_o,
    output logic [$clog2(NUM_ENTRIES)-1:0]      rsp_entry_idx_o
);

    localparam int EPC   = ENTRIES_PER_CYCLE;
    localparam int NB_W  = $clog2(DATA_WIDTH/8) + 1;
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int B     = NUM_ENTRIES / EPC;
    localparam int CNT_W = $clog2(B + 1);
    localparam int BAT_W = (B > 1) ? $clog2(B) : 1;
    localparam int CW    = ADDR_WIDTH + 3;
    localparam int RW    = 2 * LEN;

    typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_RESP} state_t;

    function automatic logic [CW-1:0] entry_base(input logic [RW-1:0] raw);
        return CW'({raw, 2'b00});
    endfunction

    function automatic int napot_shift(input logic [RW-1:0] raw);
        int   n;
        logic run;
        n   = 3;
        run = 1'b1;
        for (int i = 0; i < RW; i++) begin
            if (run && raw[i]) n++;
            else run = 1'b0;
        end
        return n;
    endfunction

    function automatic logic in_range(input mode_t m, input logic [CW-1:0] x,
                                      input logic [CW-1:0] prev, input logic [RW-1:0] raw);
        logic [CW-1:0] base;
        int            sh;
        logic          hit;
        base = entry_base(raw);
        sh   = napot_shift(raw);
        case (m)
            MODE_TOR:   hit = (x >= prev) && (x < base);
            MODE_NA4:   hit = (x >> 2) == (base >> 2);
            MODE_NAPOT: hit = (x >> sh) == (base >> sh);
            default:    hit = 1'b0;
        endcase
        return hit;
    endfunction

    state_t                   state_q, state_d;

    logic [CW-1:0]            addr_p0, final_p0;
    access_t                  access_p0;
    logic [NUM_ENTRIES-1:0]   mask_p0;

    logic [CNT_W-1:0]         rd_cnt;
    logic                     vld_p1;
    logic [BAT_W-1:0]         batch_p1;
    logic [CW-1:0]            prev_p1;

    logic                     dec_done_p1, dec_allow_p1, dec_match_p1, dec_part_p1;
    logic [IDX_W-1:0]         dec_idx_p1;
    logic                     np_hit_p1;
    logic [IDX_W-1:0]         np_idx_p1;

    logic                     allow_p2, match_p2, part_p2;
    logic [IDX_W-1:0]         idx_p2;

    logic [EPC-1:0][RW-1:0]   lane_raw;
    logic [EPC-1:0][CW-1:0]   lane_prev;
    logic [EPC-1:0]           lane_mask, lane_full, lane_part, lane_ok;

    logic                     c_prio_hit, c_prio_full, c_prio_allow;
    logic [IDX_W-1:0]         c_prio_idx;
    logic                     c_np_hit;
    logic [IDX_W-1:0]         c_np_idx;

    logic                     v_allow, v_match, v_part;
    logic [IDX_W-1:0]         v_idx;

    logic                     in_walk, accept, last_batch, decide_now;
    logic [NB_W-1:0]          nb_eff;

    assign in_walk    = (state_q == ST_WALK);
    assign accept     = (state_q == ST_IDLE) && req_valid_i;
    assign last_batch = (batch_p1 == BAT_W'(B - 1));
    assign nb_eff     = (req_num_bytes_i == '0) ? NB_W'(1) : req_num_bytes_i;

`ifdef IOPMP_EARLY_EXIT_EN
    assign decide_now = in_walk && vld_p1 && (last_batch || (c_prio_hit && !dec_done_p1));
`else
    assign decide_now = in_walk && vld_p1 && last_batch;
`endif

    // Read strobe drops in the deciding cycle so no further batch is requested.
    assign entry_rd_en_o  = in_walk && (rd_cnt < CNT_W'(B)) && !decide_now;
    assign entry_rd_idx_o = entry_rd_en_o ? IDX_W'(int'(rd_cnt) * EPC) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = ST_WALK;
            end
            ST_WALK: if (decide_now) state_d = ST_RESP;
            ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage p1: per-lane decode of the batch returned by the entry read port.
    always_comb begin
        lane_raw  = '0;
        lane_prev = '0;
        lane_full = '0;
        lane_part = '0;
        lane_ok   = '0;
        lane_mask = EPC'(mask_p0 >> (int'(batch_p1) * EPC));
        for (int l = 0; l < EPC; l++) begin
            lane_raw[l] = {entry_addrh_i[l*LEN +: LEN], entry_addr_i[l*LEN +: LEN]};
        end
        lane_prev[0] = prev_p1;
        for (int l = 1; l < EPC; l++) begin
            lane_prev[l] = entry_base(lane_raw[l-1]);
        end
        for (int l = 0; l < EPC; l++) begin
            if (lane_mask[l]) begin
                lane_full[l] = in_range(mode_t'(entry_mode_i[l*2 +: 2]), addr_p0, lane_prev[l], lane_raw[l])
                            && in_range(mode_t'(entry_mode_i[l*2 +: 2]), final_p0, lane_prev[l], lane_raw[l]);
                lane_part[l] = in_range(mode_t'(entry_mode_i[l*2 +: 2]), addr_p0, lane_prev[l], lane_raw[l])
                            && !in_range(mode_t'(entry_mode_i[l*2 +: 2]), final_p0, lane_prev[l], lane_raw[l]);
            end
            lane_ok[l] = (access_p0 & entry_perm_i[l*3 +: 3]) == access_p0;
        end
    end

    always_comb begin
        c_prio_hit   = 1'b0;
        c_prio_full  = 1'b0;
        c_prio_allow = 1'b0;
        c_prio_idx   = '0;
        c_np_hit     = 1'b0;
        c_np_idx     = '0;
        for (int l = 0; l < EPC; l++) begin
            if (int'(batch_p1) * EPC + l < PRIO_ENTRIES) begin
                if (!c_prio_hit && (lane_full[l] || lane_part[l])) begin
                    c_prio_hit   = 1'b1;
                    c_prio_full  = lane_full[l];
                    c_prio_allow = lane_full[l] && lane_ok[l];
                    c_prio_idx   = IDX_W'(int'(batch_p1) * EPC + l);
                end
            end else if (!c_np_hit && lane_full[l] && lane_ok[l]) begin
                c_np_hit = 1'b1;
                c_np_idx = IDX_W'(int'(batch_p1) * EPC + l);
            end
        end
    end

    // A held priority decision always wins; earlier non-priority allows beat later ones.
    always_comb begin
        v_allow = 1'b0;
        v_match = 1'b0;
        v_part  = 1'b0;
        v_idx   = '0;
        if (dec_done_p1) begin
            v_allow = dec_allow_p1;
            v_match = dec_match_p1;
            v_part  = dec_part_p1;
            v_idx   = dec_idx_p1;
        end else if (c_prio_hit) begin
            v_allow = c_prio_allow;
            v_match = c_prio_full;
            v_part  = !c_prio_full;
            v_idx   = c_prio_idx;
        end else if (np_hit_p1) begin
            v_allow = 1'b1;
            v_match = 1'b1;
            v_idx   = np_idx_p1;
        end else if (c_np_hit) begin
            v_allow = 1'b1;
            v_match = 1'b1;
            v_idx   = c_np_idx;
        end
    end

    // Stage p0/p1: request capture, batch sequencing and decision holding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_p0      <= '0;
            final_p0     <= '0;
            access_p0    <= '0;
            mask_p0      <= '0;
            rd_cnt       <= '0;
            vld_p1       <= 1'b0;
            batch_p1     <= '0;
            prev_p1      <= '0;
            dec_done_p1  <= 1'b0;
            dec_allow_p1 <= 1'b0;
            dec_match_p1 <= 1'b0;
            dec_part_p1  <= 1'b0;
            dec_idx_p1   <= '0;
            np_hit_p1    <= 1'b0;
            np_idx_p1    <= '0;
        end else if (accept) begin
            addr_p0      <= CW'(req_addr_i);
            final_p0     <= CW'(req_addr_i) + CW'(nb_eff) - CW'(1);
            access_p0    <= req_access_i;
            mask_p0      <= req_entry_mask_i;
            rd_cnt       <= '0;
            vld_p1       <= 1'b0;
            batch_p1     <= '0;
            prev_p1      <= '0;
            dec_done_p1  <= 1'b0;
            dec_allow_p1 <= 1'b0;
            dec_match_p1 <= 1'b0;
            dec_part_p1  <= 1'b0;
            dec_idx_p1   <= '0;
            np_hit_p1    <= 1'b0;
            np_idx_p1    <= '0;
        end else if (in_walk) begin
            vld_p1   <= entry_rd_en_o;
            batch_p1 <= BAT_W'(rd_cnt);
            if (entry_rd_en_o) rd_cnt <= rd_cnt + CNT_W'(1);
            if (vld_p1) begin
                prev_p1 <= entry_base(lane_raw[EPC-1]);
                if (c_prio_hit && !dec_done_p1) begin
                    dec_done_p1  <= 1'b1;
                    dec_allow_p1 <= c_prio_allow;
                    dec_match_p1 <= c_prio_full;
                    dec_part_p1  <= !c_prio_full;
                    dec_idx_p1   <= c_prio_idx;
                end
                if (c_np_hit && !np_hit_p1) begin
                    np_hit_p1 <= 1'b1;
                    np_idx_p1 <= c_np_idx;
                end
            end
        end else begin
            vld_p1 <= 1'b0;
        end
    end

    // Stage p2: registered verdict, held through RESP and cleared on handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            allow_p2 <= 1'b0;
            match_p2 <= 1'b0;
            part_p2  <= 1'b0;
            idx_p2   <= '0;
        end else if (decide_now) begin
            allow_p2 <= v_allow;
            match_p2 <= v_match;
            part_p2  <= v_part;
            idx_p2   <= v_idx;
        end else if ((state_q == ST_RESP) && rsp_ready_i) begin
            allow_p2 <= 1'b0;
            match_p2 <= 1'b0;
            part_p2  <= 1'b0;
            idx_p2   <= '0;
        end
    end

    assign rsp_valid_o     = (state_q == ST_RESP);
    assign rsp_allow_o     = allow_p2;
    assign rsp_match_o     = match_p2;
    assign rsp_partial_o   = part_p2;
    assign rsp_entry_idx_o = idx_p2;

endmodule

// File: tb/tb_rv_iopmp_walk_matcher.sv
// Directed scoreboard bench for rv_iopmp_walk_matcher; the bench acts as the entry register file.
module tb_rv_iopmp_walk_matcher;
    import rv_iopmp_pkg::*;

    localparam int NE  = 16;
    localparam int EPC = 4;
    localparam int LEN = 32;
    localparam int B   = NE / EPC;
`ifdef IOPMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready;
    logic [63:0]       req_addr;
    logic [3:0]        req_nb;
    access_t           req_acc;
    logic [NE-1:0]     req_mask;
    logic              rd_en;
    logic [3:0]        rd_idx;
    logic [EPC*LEN-1:0] e_addr, e_addrh;
    logic [EPC*2-1:0]  e_mode;
    logic [EPC*3-1:0]  e_perm;
    logic              rsp_valid, rsp_ready, rsp_allow, rsp_match, rsp_part;
    logic [3:0]        rsp_idx;

    logic [LEN-1:0]    t_addr [NE];
    logic [LEN-1:0]    t_addrh[NE];
    logic [1:0]        t_mode [NE];
    logic [2:0]        t_perm [NE];

    typedef struct {
        logic       allow;
        logic       match;
        logic       part;
        logic [3:0] idx;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    rv_iopmp_walk_matcher #(
        .NUM_ENTRIES(NE), .ENTRIES_PER_CYCLE(EPC), .PRIO_ENTRIES(8),
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .LEN(LEN)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_num_bytes_i(req_nb),
        .req_access_i(req_acc), .req_entry_mask_i(req_mask),
        .entry_rd_en_o(rd_en), .entry_rd_idx_o(rd_idx),
        .entry_addr_i(e_addr), .entry_addrh_i(e_addrh),
        .entry_mode_i(e_mode), .entry_perm_i(e_perm),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_allow_o(rsp_allow), .rsp_match_o(rsp_match),
        .rsp_partial_o(rsp_part), .rsp_entry_idx_o(rsp_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency entry read port; junk is driven whenever no read is issued.
    always @(posedge clk) begin
        if (rd_en) begin
            for (int l = 0; l < EPC; l++) begin
                e_addr [l*LEN +: LEN] <= t_addr [int'(rd_idx) + l];
                e_addrh[l*LEN +: LEN] <= t_addrh[int'(rd_idx) + l];
                e_mode [l*2 +: 2]     <= t_mode [int'(rd_idx) + l];
                e_perm [l*3 +: 3]     <= t_perm [int'(rd_idx) + l];
            end
        end else begin
            e_addr  <= {$urandom, $urandom, $urandom, $urandom};
            e_addrh <= {$urandom, $urandom, $urandom, $urandom};
            e_mode  <= 8'($urandom);
            e_perm  <= 12'($urandom);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_prio(input int batch);
        return EARLY ? 3 + batch : 2 + B;
    endfunction

    task automatic clear_tbl();
        for (int i = 0; i < NE; i++) begin
            t_addr[i] = '0; t_addrh[i] = '0; t_mode[i] = MODE_OFF; t_perm[i] = 3'b000;
        end
    endtask

    task automatic set_entry(input int i, input logic [31:0] a, input logic [1:0] m, input logic [2:0] p);
        t_addr[i] = a; t_addrh[i] = '0; t_mode[i] = m; t_perm[i] = p;
    endtask

    task automatic run_req(input string name, input logic [63:0] a, input logic [3:0] nb,
                           input access_t acc, input logic [NE-1:0] m,
                           input logic al, input logic ma, input logic pa,
                           input logic [3:0] ix, input int lat, input int hold);
        exp_t e, got;
        int   n, t_acc;
        e.allow = al; e.match = ma; e.part = pa; e.idx = ix; e.lat = lat;
        sb.push_back(e);
        rsp_ready = (hold == 0);
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk({name, "_req_ready"}, req_ready, 1);
        req_valid = 1'b1; req_addr = a; req_nb = nb; req_acc = acc; req_mask = m;
        t_acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        got = sb.pop_front();
        if (!rsp_valid) begin
            chk({name, "_timeout"}, rsp_valid, 1);
            rsp_ready = 1'b1;
            return;
        end
        chk({name, "_latency"}, cyc - t_acc, got.lat);
        chk({name, "_allow"},   rsp_allow,  got.allow);
        chk({name, "_match"},   rsp_match,  got.match);
        chk({name, "_partial"}, rsp_part,   got.part);
        chk({name, "_idx"},     rsp_idx,    got.idx);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({name, "_hold_valid"}, rsp_valid, 1);
            chk({name, "_hold_allow"}, rsp_allow, got.allow);
            chk({name, "_hold_idx"},   rsp_idx,   got.idx);
            chk({name, "_hold_rd_en"}, rd_en,     0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({name, "_post_valid"}, rsp_valid, 0);
        chk({name, "_post_allow"}, rsp_allow, 0);
        chk({name, "_post_match"}, rsp_match, 0);
        chk({name, "_post_idx"},   rsp_idx,   0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_addr = '0; req_nb = '0; req_acc = '0; req_mask = '0;
        clear_tbl();
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rd_en",     rd_en,     0);
        chk("rst_allow",     rsp_allow, 0);
        chk("rst_idx",       rsp_idx,   0);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 1);

        // NAPOT 4 KiB at 0x8000_0000, read-only
        set_entry(0, 32'h2000_01FF, MODE_NAPOT, ACCESS_R);
        run_req("napot_read",  64'h8000_0100, 4'd8, ACCESS_R, '1, 1, 1, 0, 0, lat_prio(0), 0);
        run_req("napot_write", 64'h8000_0100, 4'd8, ACCESS_W, '1, 0, 1, 0, 0, lat_prio(0), 0);
        run_req("napot_hold",  64'h8000_0FF8, 4'd8, ACCESS_R, '1, 1, 1, 0, 0, lat_prio(0), 5);

        // TOR [0x1000,0x2000) from entries 1/2, TOR [0x4000,0x5000) across the batch edge
        clear_tbl();
        set_entry(1, 32'h0000_0400, MODE_OFF, 3'b000);
        set_entry(2, 32'h0000_0800, MODE_TOR, ACCESS_R | ACCESS_W);
        set_entry(3, 32'h0000_1000, MODE_OFF, 3'b000);
        set_entry(4, 32'h0000_1400, MODE_TOR, ACCESS_R);
        run_req("tor_partial", 64'h1FFC, 4'd8, ACCESS_R, '1, 0, 0, 1, 2, lat_prio(0), 0);
        run_req("tor_full",    64'h1000, 4'd8, ACCESS_R, '1, 1, 1, 0, 2, lat_prio(0), 0);
        run_req("tor_below",   64'h0FFC, 4'd8, ACCESS_R, '1, 0, 0, 0, 0, 2 + B, 0);
        run_req("tor_batch1",  64'h4800, 4'd4, ACCESS_R, '1, 1, 1, 0, 4, lat_prio(1), 0);

        clear_tbl();
        run_req("all_off", 64'hDEAD_0000, 4'd8, ACCESS_R, '1, 0, 0, 0, 0, 2 + B, 0);

        // Non-priority NA4 at entry 10 and NAPOT at entry 12 over 0x3000
        set_entry(10, 32'h0000_0C00, MODE_NA4,   ACCESS_R | ACCESS_W);
        set_entry(12, 32'h0000_0DFF, MODE_NAPOT, ACCESS_R | ACCESS_W);
        run_req("np_na4",      64'h3000, 4'd4, ACCESS_W, '1,                   1, 1, 0, 10, 2 + B, 0);
        run_req("np_mask10",   64'h3000, 4'd4, ACCESS_W, ~(16'h1 << 10),       1, 1, 0, 12, 2 + B, 0);
        run_req("np_noperm",   64'h3000, 4'd4, ACCESS_X, '1,                   0, 0, 0, 0,  2 + B, 0);
        run_req("np_nb0",      64'h3000, 4'd0, ACCESS_W, ~(16'h1 << 12),       1, 1, 0, 10, 2 + B, 0);
        run_req("np_na4_edge", 64'h3002, 4'd4, ACCESS_W, ~(16'h1 << 12),       0, 0, 0, 0,  2 + B, 0);
        set_entry(5, 32'h0000_0DFF, MODE_NAPOT, ACCESS_R);
        run_req("prio_wins",   64'h3000, 4'd4, ACCESS_W, '1,                   0, 1, 0, 5,  lat_prio(1), 0);
        run_req("prio_masked", 64'h3000, 4'd4, ACCESS_W, ~(16'h1 << 5),        1, 1, 0, 10, 2 + B, 0);

        // Reset in the middle of a walk
        clear_tbl();
        @(negedge clk);
        req_valid = 1'b1; req_addr = 64'hDEAD_0000; req_nb = 4'd8; req_acc = ACCESS_R; req_mask = '1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("walk_rd_en",   rd_en,  1);
        chk("walk_rd_idx0", rd_idx, 0);
        @(negedge clk);
        chk("walk_rd_idx1", rd_idx, 4);
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rd_en",     rd_en,     0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_req_ready", req_ready, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, 0);
        end
        set_entry(0, 32'h2000_01FF, MODE_NAPOT, ACCESS_R);
        run_req("after_reset", 64'h8000_0100, 4'd8, ACCESS_R, '1, 1, 1, 0, 0, lat_prio(0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_iopmp_walk_matcher.md
Name: rv_iopmp_walk_matcher

Overview:
Sequential, parametrised IOPMP matching engine that replaces the per-entry combinational check for large entry tables. For each accepted transaction it walks the entry table ENTRIES_PER_CYCLE entries per cycle and decodes OFF/TOR/NA4/NAPOT per lane. It applies priority/non-priority resolution and returns a single allow/deny verdict through a valid/ready response channel. It sits between the transaction front-end and the entry register file, and reads entries through a one-cycle-latency read port.

Parameters:
NUM_ENTRIES, 16, total entries; must be a multiple of ENTRIES_PER_CYCLE.
ENTRIES_PER_CYCLE, 4, entries evaluated in parallel per cycle (lanes).
PRIO_ENTRIES, 8, entries with index < PRIO_ENTRIES are priority entries.
ADDR_WIDTH, 64, transaction address width.
DATA_WIDTH, 64, bus data width; sizes num_bytes_i.
LEN, 32, entry register width (addr/addrh hold address[65:2]).

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready
req_addr_i  in  ADDR_WIDTH  first byte address
req_num_bytes_i  in  $clog2(DATA_WIDTH/8)+1  byte count
req_access_i  in  rv_iopmp_pkg::access_t  requested access type
req_entry_mask_i  in  NUM_ENTRIES  entries belonging to the requester's memory domains
entry_rd_en_o  out  1  entry batch read strobe
entry_rd_idx_o  out  $clog2(NUM_ENTRIES)  index of lane 0 of the batch
entry_addr_i  in  ENTRIES_PER_CYCLE*LEN  addr registers, valid one cycle after the read
entry_addrh_i  in  ENTRIES_PER_CYCLE*LEN  addrh registers
entry_mode_i  in  ENTRIES_PER_CYCLE*2  rv_iopmp_pkg::mode_t per lane
entry_perm_i  in  ENTRIES_PER_CYCLE*3  access permissions per lane
rsp_valid_o  out  1  verdict valid
rsp_ready_i  in  1  verdict accepted
rsp_allow_o  out  1  transaction permitted
rsp_match_o  out  1  an entry fully matched
rsp_partial_o  out  1  a priority entry partially matched
rsp_entry_idx_o  out  $clog2(NUM_ENTRIES)  deciding entry index (0 if none)

Behaviour:
- Reset (async, rst_ni=0): state IDLE; all rsp_* and entry_rd_* outputs 0; internal registers cleared. req_ready_o=1 whenever state==IDLE, including the first cycle after reset release. Reset mid-walk or mid-response aborts the walk with no response.
- FSM: IDLE -> WALK on req handshake; WALK -> RESP on decision; RESP -> IDLE on rsp_valid_o & rsp_ready_i. There is no same-cycle re-accept. req_ready_o=0 outside IDLE.
- On accept, register addr, access, mask, and final = addr + max(num_bytes,1) - 1. num_bytes 0 is treated as 1.
- WALK: batch k (k=0..B-1, B=NUM_ENTRIES/ENTRIES_PER_CYCLE) is read in cycle t+1+k with entry_rd_idx_o = k*ENTRIES_PER_CYCLE. Its data is evaluated in cycle t+2+k.
- Per lane: entry address = {addrh,addr}<<2, zero-extended to ADDR_WIDTH+3 bits before compare.
  - TOR: range is [prev, cur). prev for lane 0 is the last lane of the previous batch, held in a register; for batch 0 it is 0. prev is updated regardless of mask/mode.
  - NA4: size 2.
  - NAPOT: size = trailing ones of {addrh,addr} + 3.
  - Full match: addr and final both inside the range. Partial match: addr inside, final outside. Masked-off or OFF lanes never match.
- Resolution, scanning lanes by ascending index:
  - Lowest-index priority entry with a full or partial match decides. Full match: allow = (access & perm)==access. Partial match: allow=0, partial=1.
  - If no priority entry matched after the walk, the first non-priority full match with sufficient permission allows. Otherwise allow=0.
  - match=1 iff the deciding entry fully matched.
- Verdict is registered: rsp_valid_o rises the cycle after the decision. Best case is t+3; worst case is t+2+B.
- RESP: all rsp_* are stable while rsp_ready_i=0. All rsp_* return to 0 on leaving RESP.
- Early exit discards in-flight read data; entry_rd_en_o drops the cycle the decision is taken.

Optional Feature:
IOPMP_EARLY_EXIT_EN:
- Defined: the walk terminates on the first priority-entry decision, giving variable latency.
- Undefined: all B batches are always walked and the verdict issues at t+2+B, giving constant, timing-side-channel-free latency.
- The verdict is identical in both cases.

Test Plan:
1. NUM=16, EPC=4, PRIO=8, early exit on. Entry0 NAPOT addr=(0x8000_0000>>2)|0x1FF (4 KiB), perm R; read 0x8000_0100, 8 B, accepted at t -> rsp_valid t+3, allow=1, match=1, idx=0.
2. Same entry, write request -> allow=0, match=1, idx=0. With IOPMP_EARLY_EXIT_EN undefined, rsp_valid is at t+6.
3. Entry1 addr=0x400, entry2 TOR addr=0x800, perm RW; read 0x1FFC, 8 B -> partial=1, allow=0, idx=2.
4. All entries OFF, read 0xDEAD_0000 -> allow=0, match=0, idx=0, rsp_valid t+6.
5. Entry10 NA4 addr=0x3000>>2, perm RW; entry12 NAPOT covering the same range; write 0x3000, 4 B -> allow=1, idx=10, rsp_valid t+6. The same request with mask bit 10 cleared -> idx=12.
6. Hold rsp_ready_i=0 for 5 cycles -> rsp fields constant. Pull rst_ni low during WALK -> rsp_valid_o=0 immediately, req_ready_o=1 on release.
